step_pulse_gen: RTL and testbench

Fast-domain consumer of the board's slow timing sources for the stepping CPU. It runs on the 50 MHz clk_in and never uses a divided clock as a clock. It synchronizes the divided slow clock and the single-step pushbutton, edge-detects and debounces them, and issues one-cycle `step_en` clock-enable pulses to the CPU core according to the selected run mode. It replaces clocking the core directly from a derived clock.

---
 rtl/step_pulse_gen.sv | 205 ++++++++++++++++++++
 tb/tb_step_pulse_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Fast-domain step-enable generator for the stepping CPU. Everything runs
//   on clk_in. The divided slow clock and the step pushbutton are sampled
//   as ordinary asynchronous data. They are never used as clocks. The block
//   turns them into one-cycle clock-enable pulses for the core.
//
//   Parameters
//     DEBOUNCE_CYCLES : stable clk_in cycles needed to accept a button change
//     CNT_W           : debounce counter width (2**CNT_W >= DEBOUNCE_CYCLES)
//     COUNT_W         : width of step_count
//
//   Ports
//     clk_in     in   50 MHz system clock
//     reset_n    in   asynchronous active-low reset
//     mode       in   00 HALT, 01 RUN, 10 SLOW, 11 STEP (clk_in synchronous)
//     slow_clk   in   divided clock, treated as asynchronous data
//     btn_n      in   raw active-low step button (bouncy, asynchronous)
//     step_en    out  registered one-cycle CPU clock enable
//     step_count out  running count of step_en cycles (STEP_COUNT_EN only)
//     btn_held   out  debounced button is in the pressed half of the FSM
//
//   Build option
//     STEP_COUNT_EN : when defined, builds the step_count counter.
//                     Otherwise step_count is tied to zero.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int COUNT_W         = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic               slow_clk,
  input  logic               btn_n,
  output logic               step_en,
  output logic [COUNT_W-1:0] step_count,
  output logic               btn_held
);

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // slow_clk: 2-flop synchronizer (s1, s2) plus delay flop s3 for edge detect
  logic slow_s1, slow_s2, slow_s3;
  logic slow_rise;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_s1 <= 1'b0;
      slow_s2 <= 1'b0;
      slow_s3 <= 1'b0;
    end else begin
      slow_s1 <= slow_clk;
      slow_s2 <= slow_s1;
      slow_s3 <= slow_s2;
    end
  end

  // s3 resets low, but a slow_clk that is already high when SLOW is
  // entered is only caught if its rise falls inside SLOW. Edges seen in
  // other modes are simply dropped.
  assign slow_rise = slow_s2 & ~slow_s3;

  // btn_n synchronizer. It resets to 1 so the button reads as released.
  logic btn_s1, btn_s2;
  logic pressed;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
    end
  end

  assign pressed = ~btn_s2;

  // mode register
  logic [1:0] mode_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) mode_q <= MODE_HALT;
    else          mode_q <= mode;
  end

  // Button debounce FSM. cnt measures how long the synchronized level has
  // been stable in a *_WAIT state. It is cleared on every state change, so
  // any bounce restarts the measurement.
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_evt, press_evt_nxt;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    press_evt_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pressed) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = ST_HELD;
          cnt_nxt       = '0;
          press_evt_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // A re-press while the release is being debounced is contact
        // bounce. The FSM returns to HELD without a new event.
        if (pressed) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // press_evt is registered alongside the move into HELD. step_en therefore
  // sees the press one edge after HELD is entered.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_evt <= press_evt_nxt;
    end
  end

  assign btn_held = (state == ST_HELD) || (state == ST_RELEASE_WAIT);

  // step_en select. Events that belong to another mode are ignored, not
  // held over.
  logic step_en_nxt;

  always_comb begin
    step_en_nxt = 1'b0;
    case (mode_q)
      MODE_HALT: step_en_nxt = 1'b0;
      MODE_RUN:  step_en_nxt = 1'b1;
      MODE_SLOW: step_en_nxt = slow_rise;
      MODE_STEP: step_en_nxt = press_evt;
      default:   step_en_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) step_en <= 1'b0;
    else          step_en <= step_en_nxt;
  end

`ifdef STEP_COUNT_EN
  // The counter advances on the same edge that raises step_en. It
  // therefore always equals the number of step_en cycles issued so far,
  // including the current one. It wraps naturally at 2**COUNT_W.
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)         count_q <= '0;
    else if (step_en_nxt) count_q <= count_q + COUNT_W'(1);
  end

  assign step_count = count_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES = 4.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point. Loop index j therefore equals the number of edges
// since the input change.
module tb_step_pulse_gen;

  localparam int COUNT_W = 16;
`ifdef STEP_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               reset_n;
  logic [1:0]         mode;
  logic               slow_clk;
  logic               btn_n;
  logic               step_en;
  logic [COUNT_W-1:0] step_count;
  logic               btn_held;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt;
  int pulses;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .COUNT_W        (COUNT_W)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .mode      (mode),
    .slow_clk  (slow_clk),
    .btn_n     (btn_n),
    .step_en   (step_en),
    .step_count(step_count),
    .btn_held  (btn_held)
  );

  always #10 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(step_count), CNT_ON ? 32'(exp_cnt) : 32'd0);
  endtask

  // Clean press and release. Sync takes 2 edges, IDLE->PRESS_WAIT 1 edge,
  // and cnt 0..3 takes 4 edges. HELD is entered at edge 7 and step_en rises
  // at edge 8. On release, RELEASE_WAIT is entered at edge 3 and IDLE at
  // edge 7.
  task automatic do_press(input logic exp_pulse, input string tag);
    btn_n = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check({tag, "_en"},   step_en,  exp_pulse && (j == 8));
      check({tag, "_held"}, btn_held, j >= 7);
    end
    btn_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check({tag, "_rel_held"}, btn_held, j < 7);
      check({tag, "_rel_en"},   step_en,  1'b0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    mode     = 2'b00;
    slow_clk = 1'b0;
    btn_n    = 1'b1;
    exp_cnt  = 0;
    repeat (3) tick();
    check("rst_en",    step_en,  1'b0);
    check("rst_held",  btn_held, 1'b0);
    check_cnt("rst_cnt");
    reset_n = 1'b1;

    // RUN: mode_q is RUN at edge 1, and step_en is high from edge 2.
    mode = 2'b01;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("run_en", step_en, j >= 2);
    end
    exp_cnt = 9;
    check_cnt("run_cnt");
    mode = 2'b00;
    tick();
    check("halt_lag_en", step_en, 1'b1);
    tick();
    check("halt_en", step_en, 1'b0);
    exp_cnt = 10;
    check_cnt("halt_cnt");

    // SLOW: three rises, each giving a pulse at the 3rd edge after the change.
    mode = 2'b10;
    tick(); tick();
    for (int r = 0; r < 3; r++) begin
      slow_clk = 1'b1;
      for (int j = 1; j <= 20; j++) begin
        tick();
        check("slow_hi_en", step_en, j == 3);
      end
      slow_clk = 1'b0;
      for (int j = 1; j <= 20; j++) begin
        tick();
        check("slow_lo_en", step_en, 1'b0);
      end
    end
    exp_cnt = 13;
    check_cnt("slow_cnt");

    // STEP: clean press with exact latency.
    mode = 2'b11;
    tick(); tick();
    do_press(1'b1, "step_clean");
    exp_cnt = 14;
    check_cnt("step_clean_cnt");

    // STEP: bounce in, long hold, bounce out. The result is exactly one pulse.
    pulses = 0;
    btn_n = 1'b0; tick(); pulses += int'(step_en);
    btn_n = 1'b1; tick(); pulses += int'(step_en);
    btn_n = 1'b0; tick(); pulses += int'(step_en);
    btn_n = 1'b1; tick(); pulses += int'(step_en);
    check("bounce_in_held", btn_held, 1'b0);
    btn_n = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      tick(); pulses += int'(step_en);
    end
    check("bounce_hold_held", btn_held, 1'b1);
    check("bounce_hold_pulses", pulses, 1);
    btn_n = 1'b1; tick(); pulses += int'(step_en);
    btn_n = 1'b0; tick(); pulses += int'(step_en);
    btn_n = 1'b1; tick(); pulses += int'(step_en);
    btn_n = 1'b0; tick(); pulses += int'(step_en);
    check("bounce_out_held", btn_held, 1'b1);
    btn_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick(); pulses += int'(step_en);
    end
    check("bounce_rel_held", btn_held, 1'b0);
    check("bounce_pulses", pulses, 1);
    exp_cnt = 15;
    check_cnt("bounce_cnt");

    // STEP: a 3-cycle glitch never reaches HELD. The clean press that follows
    // still has nominal latency, which shows the FSM went back to IDLE.
    pulses = 0;
    btn_n = 1'b0;
    repeat (3) begin tick(); pulses += int'(step_en); end
    btn_n = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      tick(); pulses += int'(step_en);
      check("glitch_held", btn_held, 1'b0);
    end
    check("glitch_pulses", pulses, 0);
    do_press(1'b1, "post_glitch");
    exp_cnt = 16;
    check_cnt("post_glitch_cnt");

    // HALT press is discarded. Entering SLOW with slow_clk already high
    // gives no pulse until the next rise.
    mode = 2'b00;
    tick(); tick();
    do_press(1'b0, "halt_press");
    slow_clk = 1'b1;
    repeat (5) tick();
    mode = 2'b10;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("slow_enter_hi_en", step_en, 1'b0);
    end
    slow_clk = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("slow_enter_lo_en", step_en, 1'b0);
    end
    slow_clk = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("slow_next_rise_en", step_en, j == 3);
    end
    slow_clk = 1'b0;
    repeat (5) tick();
    exp_cnt = 17;
    check_cnt("slow_enter_cnt");

    // Reset asserted while in PRESS_WAIT.
    mode = 2'b11;
    tick(); tick();
    btn_n = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    btn_n   = 1'b1;
    #1;
    exp_cnt = 0;
    check("rst2_en",   step_en,  1'b0);
    check("rst2_held", btn_held, 1'b0);
    check_cnt("rst2_cnt");
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int j = 1; j <= 15; j++) begin
      tick(); pulses += int'(step_en);
    end
    check("rst2_pulses", pulses, 0);
    check("rst2_held_after", btn_held, 1'b0);

    // Counter wrap: after edge k in RUN the count is k-1.
    mode = 2'b01;
`ifdef STEP_COUNT_EN
    repeat (65536) tick();
    check("wrap_pre_cnt", 32'(step_count), 32'h0000_FFFF);
    check("wrap_pre_en",  step_en, 1'b1);
    mode = 2'b00;
    tick();
    check("wrap_cnt", 32'(step_count), 32'd0);
    check("wrap_en",  step_en, 1'b1);
    tick();
    check("wrap_post_en",  step_en, 1'b0);
    check("wrap_post_cnt", 32'(step_count), 32'd0);
`else
    repeat (20) tick();
    check("nocnt_run_en",  step_en, 1'b1);
    check("nocnt_run_cnt", 32'(step_count), 32'd0);
    mode = 2'b00;
    tick(); tick();
    check("nocnt_halt_en", step_en, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
